// File: rtl/mac_conv_seq_param_if.sv
// Start/operand and result handshake bundle for mac_conv_seq_param.
interface mac_conv_seq_param_if #(
  parameter int N    = 8,
  parameter int TAPS = 9
);
  logic              st;
  logic [N*TAPS-1:0] pix;
  logic [N*TAPS-1:0] k;
  logic              busy;
  logic [N-1:0]      out;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output st, pix, k, out_ready,
    input  busy, out, out_valid
  );

  modport slave (
    input  st, pix, k, out_ready,
    output busy, out, out_valid
  );
endinterface

// File: rtl/mac_conv_seq_param.sv
// Sequential single-multiplier MAC: TAPS cycles per pixel, result held in HOLD until out_ready.
// Optional macro SAT_EN clamps the scaled result to 2^N-1 instead of truncating.
module mac_conv_seq_param #(
  parameter int N     = 8,
  parameter int TAPS  = 9,
  parameter int SHIFT = 7
) (
  input logic                  clk,
  input logic                  rst,
  mac_conv_seq_param_if.slave  bus
);
  localparam int ACC_W = 2 * N + $clog2(TAPS);
  localparam int CNT_W = $clog2(TAPS);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t             state, state_nx;
  logic [N*TAPS-1:0]  pix_l, k_l;
  logic [ACC_W-1:0]   acc, acc_nx;
  logic [CNT_W-1:0]   cnt;
  logic [N-1:0]       out_r;
  logic [N-1:0]       pa, pb;
  logic [2*N-1:0]     prod;
  logic               load, last;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    last     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.st) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (cnt == CNT_W'(TAPS - 1)) begin
          last     = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        // st only matters once the current result has been taken
        if (bus.out_ready) begin
          if (bus.st) begin
            load     = 1'b1;
            state_nx = RUN;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    pa     = pix_l[int'(cnt) * N +: N];
    pb     = k_l[int'(cnt) * N +: N];
    prod   = pa * pb;
    acc_nx = acc + ACC_W'(prod);
  end

  // Operand snapshot; contents are don't-care until the first load.
  always_ff @(posedge clk) begin
    if (load) begin
      pix_l <= bus.pix;
      k_l   <= bus.k;
    end
  end

`ifdef SAT_EN
  localparam logic [ACC_W-1:0] MAXV = {{(ACC_W - N){1'b0}}, {N{1'b1}}};
  logic [N-1:0] scaled;
  assign scaled = ((acc_nx >> SHIFT) > MAXV) ? {N{1'b1}} : N'(acc_nx >> SHIFT);
`else
  logic [N-1:0] scaled;
  assign scaled = N'(acc_nx >> SHIFT);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc   <= '0;
      cnt   <= '0;
      out_r <= '0;
    end else if (load) begin
      acc <= '0;
      cnt <= '0;
    end else if (state == RUN) begin
      acc <= acc_nx;
      cnt <= cnt + 1'b1;
      if (last) out_r <= scaled;
    end
  end

  assign bus.out       = out_r;
  assign bus.out_valid = (state == HOLD);
  assign bus.busy      = (state == RUN);
endmodule

// File: tb/tb_mac_conv_seq_param.sv
// Directed bench for mac_conv_seq_param with N=8, TAPS=9, SHIFT=7.
module tb_mac_conv_seq_param;
  localparam int N = 8;
  localparam int TAPS = 9;

`ifdef SAT_EN
  localparam logic [7:0] OVF_EXP = 8'd255;
`else
  localparam logic [7:0] OVF_EXP = 8'd220;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mac_conv_seq_param_if #(.N(N), .TAPS(TAPS)) bus ();

  mac_conv_seq_param #(.N(N), .TAPS(TAPS), .SHIFT(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic set_window(input logic [7:0] p, input logic [7:0] kk);
    for (int i = 0; i < TAPS; i++) begin
      bus.pix[i*N +: N] = p;
      bus.k[i*N +: N]   = kk;
    end
  endtask

  // Drives st for one edge (E0) and returns #1 after it.
  task automatic pulse_start();
    bus.st = 1'b1;
    edges(1);
    bus.st = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.st = 1'b0;
    bus.out_ready = 1'b1;
    set_window(8'd0, 8'd0);
    edges(3);
    rst = 1'b1;
    edges(1);
    checks++; if (bus.out !== 8'd0) begin errors++; $display("FAIL reset_out: got %0d expected 0", bus.out); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    begin
      int seen = 0;
      for (int i = 0; i < 20; i++) begin
        edges(1);
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL idle_quiet: got %0d active cycles expected 0", seen); end
    end
  endtask

  task automatic test_uniform();
    int bad = 0;
    set_window(8'd10, 8'd14);
    bus.out_ready = 1'b1;
    pulse_start();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL uniform_busy_e0: got %b expected 1", bus.busy); end
    for (int i = 1; i < TAPS; i++) begin
      edges(1);
      if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL uniform_run: got %0d bad cycles expected 0", bad); end
    edges(1);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL uniform_valid_e9: got %b expected 1", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL uniform_busy_e9: got %b expected 0", bus.busy); end
    checks++; if (bus.out !== 8'd9) begin errors++; $display("FAIL uniform_out: got %0d expected 9", bus.out); end
    edges(1);
    checks++; if (bus.out_valid !== 1'b0 || bus.out !== 8'd9) begin
      errors++; $display("FAIL uniform_release: got valid=%b out=%0d expected valid=0 out=9", bus.out_valid, bus.out);
    end
  endtask

  task automatic test_latching();
    set_window(8'd10, 8'd14);
    bus.pix[0 +: N] = 8'd19;
    bus.out_ready = 1'b1;
    pulse_start();
    set_window(8'd0, 8'd14);
    edges(TAPS);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL latch_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.out !== 8'd10) begin errors++; $display("FAIL latch_out: got %0d expected 10", bus.out); end
    edges(1);
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    set_window(8'd255, 8'd255);
    bus.out_ready = 1'b0;
    pulse_start();
    set_window(8'd10, 8'd14);
    edges(TAPS - 1);
    // second window differs so an ignored st would still be visible later
    set_window(8'd255, 8'd255);
    edges(1);
    for (int i = 0; i < 5; i++) begin
      bus.st = i[0];
      edges(1);
      if (bus.out_valid !== 1'b1 || bus.busy !== 1'b0 || bus.out !== OVF_EXP) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL hold_stable: got %0d unstable cycles expected 0", bad); end
    set_window(8'd10, 8'd14);
    bus.st = 1'b1;
    bus.out_ready = 1'b1;
    edges(1);
    bus.st = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", bus.busy); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop: got %b expected 0", bus.out_valid); end
    edges(TAPS - 1);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_early: got %b expected 0", bus.out_valid); end
    edges(1);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.out !== 8'd9) begin errors++; $display("FAIL b2b_out: got %0d expected 9", bus.out); end
    edges(1);
  endtask

  task automatic test_overflow();
    set_window(8'd255, 8'd255);
    bus.out_ready = 1'b1;
    pulse_start();
    edges(TAPS);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.out !== OVF_EXP) begin errors++; $display("FAIL ovf_out: got %0d expected %0d", bus.out, OVF_EXP); end
    edges(1);
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    set_window(8'd10, 8'd14);
    bus.out_ready = 1'b1;
    pulse_start();
    edges(3);
    rst = 1'b0;
    edges(1);
    rst = 1'b1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.out !== 8'd0) begin errors++; $display("FAIL rmid_out: got %0d expected 0", bus.out); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", bus.out_valid); end
    for (int i = 0; i < 12; i++) begin
      edges(1);
      if (bus.out_valid !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rmid_no_pulse: got %0d valid cycles expected 0", seen); end
    pulse_start();
    edges(TAPS);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rmid_restart_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.out !== 8'd9) begin errors++; $display("FAIL rmid_restart_out: got %0d expected 9", bus.out); end
    edges(1);
  endtask

  initial begin
    bus.st = 1'b0;
    bus.out_ready = 1'b1;
    bus.pix = '0;
    bus.k = '0;
    test_reset();
    test_uniform();
    test_latching();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_conv_seq_param.md
# mac_conv_seq_param

Parametrised single-multiplier sequential multiply-accumulate engine for the convolution datapath. It computes one output pixel as the sum of TAPS pixel×kernel products, one product per clock, then scales and narrows the result. Operands are latched at start, and the result is offered on a valid/ready output handshake, so the upstream window buffer may change during computation. It supersedes the fixed 3×3 sequential MAC and feeds the output-pixel writer.

## Interface
- N, 8, pixel and kernel coefficient width (unsigned)
- TAPS, 9, number of products per output (kernel size); 2..64
- SHIFT, 7, right shift applied to the accumulator to form the output
- clk  input  1  rising-edge clock; single clock domain
- rst  input  1  synchronous, active-low reset (sampled on rising clk)
- st  input  1  start request; accepted only as defined below
- pix  input  N*TAPS  pixel window, tap i at [i*N +: N]
- k  input  N*TAPS  kernel coefficients, tap i at [i*N +: N]
- busy  output  1  high in RUN
- out  output  N  registered scaled result
- out_valid  output  1  result available (HOLD state)
- out_ready  input  1  downstream accepts result

## Operation
- Accumulator width ACC_W = 2N + clog2(TAPS); product and accumulation are unsigned, full width, with no internal overflow.
- States:
  - IDLE: waiting for st.
  - RUN: accumulating; cnt counts 0..TAPS-1.
  - HOLD: result presented.
- IDLE, st=1: latch pix and k into internal registers, acc←0, cnt←0, go to RUN.
- RUN, each cycle: acc←acc + pix_l[cnt]·k_l[cnt], cnt←cnt+1.
  - When cnt==TAPS-1, the last product is added and the state goes to HOLD.
  - In the same edge, out←scale(acc_final) and out_valid←1.
- scale(x) = (x >> SHIFT) truncated to the low N bits; see Configuration for the saturating variant.
- HOLD:
  - out and out_valid are held stable until out_ready=1.
  - out_ready=1, st=0: go to IDLE, out_valid←0; out keeps its last value.
  - out_ready=1, st=1: back-to-back. Latch new operands, go directly to RUN, out_valid←0.
  - out_ready=0: st is ignored.
- st in RUN is ignored; it is not queued.
- Input changes on pix or k after the start edge have no effect on the current result.

## Timing
- Reset (rst=0 at an edge): state←IDLE, acc←0, cnt←0, out←0, out_valid←0, busy←0. This applies from any state, including mid-RUN and in HOLD. The partial result is discarded, and no out_valid pulse follows.
- Latency: with st sampled at edge E0, out_valid is first high after edge E_TAPS (TAPS cycles). busy is high from E0 to E_TAPS.
- Throughput: with out_ready tied high and st held high, one result is produced every TAPS+1 cycles. The +1 is the HOLD cycle.
- out is a registered output. out_valid is decoded from the state register; there is no combinational path from inputs to outputs.
- When rst and st are both active at an edge, reset wins.

## Configuration
- Macro SAT_EN:
  - Defined: when (acc >> SHIFT) > 2^N−1, out←2^N−1; otherwise out←(acc >> SHIFT).
  - Undefined: plain truncation to the low N bits, with no saturation logic generated.
- The macro has no effect on timing or state behaviour.

## Test plan
All scenarios use N=8, TAPS=9, SHIFT=7.
- Reset/idle: hold rst=0 for 3 cycles, then release → out=0, out_valid=0, busy=0. st=0 for 20 cycles → out_valid stays 0.
- Uniform window: all pix=10, all k=14, st pulsed at E0, out_ready=1 → busy for edges E0..E9, out_valid after E9, out=9 (1260>>7).
- Operand latching and mixed values: pix0=19, others 10, k=14. Change all pix to 0 one cycle after start → out=10 (1386>>7).
- Back-pressure and back-to-back:
  - Hold out_ready=0 for 5 cycles in HOLD → out and out_valid stable, st pulses ignored.
  - Then out_ready=1 with st=1 → next RUN starts without an IDLE cycle, and the second result (pix=10, k=14) gives out=9.
- Overflow: all pix=255, k=255 → out=220 without SAT_EN, and out=255 with SAT_EN defined (585225>>7=4572).
- Reset mid-operation: assert rst=0 at cycle 4 of RUN → state IDLE, out=0, and no out_valid. A subsequent start yields the correct out=9.
